// File: rtl/hazard_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_mon_pkg
// Purpose  : Opcodes, error codes, state type and source-usage helpers for the
//            hazard stall monitor.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_mon_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] AMO    = 7'b0101111;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_MISSING = 2'b01,
    ERR_EARLY   = 2'b10,
    ERR_LONG    = 2'b11
  } err_code_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CHK  = 1'b1
  } mon_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == LUI) || (op == AUIPC) || (op == JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == BRANCH) || (op == STORE) || (op == OP) || (op == AMO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_req_decode.sv
`default_nettype none
// ============================================================================
// Module   : hazard_req_decode
// Purpose  : Combinational required-stall-length decode from ID/EX/MEM state.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_req_decode
  import hazard_mon_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             id_valid_i,
  input  logic [6:0]       id_opcode_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [1:0]       id_branch_i,
  input  logic [6:0]       ex_opcode_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_regwr_i,
  input  logic [6:0]       mem_opcode_i,
  input  logic [REG_W-1:0] mem_rd_i,
  output logic [1:0]       req_o
);

  logic w_src1;
  logic w_src2;
  logic w_br;
  logic w_ex_load;
  logic w_mem_load;
  logic w_ex_hit;
  logic w_mem_hit;

  assign w_src1     = uses_rs1(id_opcode_i);
  assign w_src2     = uses_rs2(id_opcode_i);
  assign w_br       = (id_branch_i == 2'b01);
  assign w_ex_load  = (ex_opcode_i == LOAD);
  assign w_mem_load = (mem_opcode_i == LOAD);

  // x0 is hardwired to zero, so it never carries a real dependence
  assign w_ex_hit  = (ex_rd_i != '0) &&
                     ((w_src1 && (id_rs1_i == ex_rd_i)) || (w_src2 && (id_rs2_i == ex_rd_i)));
  assign w_mem_hit = (mem_rd_i != '0) &&
                     ((w_src1 && (id_rs1_i == mem_rd_i)) || (w_src2 && (id_rs2_i == mem_rd_i)));

  always_comb begin
    req_o = 2'd0;
    if (id_valid_i) begin
      if (w_br) begin
        if (w_ex_load && w_ex_hit) begin
          req_o = 2'd2;
        end else if ((ex_regwr_i && w_ex_hit) || (w_mem_load && w_mem_hit)) begin
          req_o = 2'd1;
        end
      end else if (w_ex_load && w_ex_hit) begin
        req_o = 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_monitor.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_monitor
// Purpose  : Passive checker flagging missing, early-released or over-long
//            hazard stalls. Define STALL_MON_STATS_EN for statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_monitor
  import hazard_mon_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int MAX_STALL = 2,
  parameter int RUN_W     = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic [6:0]       id_opcode_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [1:0]       id_branch_i,
  input  logic [6:0]       ex_opcode_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_regwr_i,
  input  logic [6:0]       mem_opcode_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             stall_i,
  input  logic             ext_stall_i,
  input  logic             flush_i,
  output logic [1:0]       req_o,
  output logic [RUN_W-1:0] run_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic             err_sticky_o
`ifdef STALL_MON_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] hazard_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
`endif
);

  logic [1:0]       w_req;
  mon_state_e       r_state;
  mon_state_e       w_state_nx;
  logic [1:0]       r_rem;
  logic [1:0]       w_rem_nx;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nx;
  logic             w_e01;
  logic             w_e10;
  logic             w_e11;
  logic             w_inc;
  err_code_e        w_code;
  logic             r_err;
  err_code_e        r_code;
  logic             r_sticky;

  hazard_req_decode #(
    .REG_W(REG_W)
  ) u_decode (
    .id_valid_i  (id_valid_i),
    .id_opcode_i (id_opcode_i),
    .id_rs1_i    (id_rs1_i),
    .id_rs2_i    (id_rs2_i),
    .id_branch_i (id_branch_i),
    .ex_opcode_i (ex_opcode_i),
    .ex_rd_i     (ex_rd_i),
    .ex_regwr_i  (ex_regwr_i),
    .mem_opcode_i(mem_opcode_i),
    .mem_rd_i    (mem_rd_i),
    .req_o       (w_req)
  );

  always_comb begin
    w_state_nx = r_state;
    w_rem_nx   = r_rem;
    w_e01      = 1'b0;
    w_e10      = 1'b0;
    if (flush_i) begin
      w_state_nx = IDLE;
      w_rem_nx   = 2'd0;
    end else if (!ext_stall_i) begin
      case (r_state)
        IDLE: begin
          if (w_req != 2'd0) begin
            if (stall_i) begin
              w_state_nx = CHK;
              w_rem_nx   = w_req - 2'd1;
            end else begin
              w_e01 = 1'b1;
            end
          end
        end
        CHK: begin
          if (r_rem != 2'd0) begin
            if (!stall_i) begin
              w_e10      = 1'b1;
              w_state_nx = IDLE;
              w_rem_nx   = 2'd0;
            end else begin
              w_rem_nx = r_rem - 2'd1;
            end
          end else begin
            w_state_nx = IDLE;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_rem_nx   = 2'd0;
        end
      endcase
    end
  end

  // Excused stalls freeze the run length rather than breaking the run
  assign w_inc = stall_i && !ext_stall_i && !flush_i;

  always_comb begin
    w_run_nx = r_run;
    if (flush_i) begin
      w_run_nx = '0;
    end else if (ext_stall_i) begin
      w_run_nx = r_run;
    end else if (stall_i) begin
      w_run_nx = (r_run == '1) ? r_run : r_run + 1'b1;
    end else begin
      w_run_nx = '0;
    end
  end

  assign w_e11 = w_inc && (r_run == RUN_W'(MAX_STALL));

  always_comb begin
    w_code = ERR_NONE;
    if (w_e10) begin
      w_code = ERR_EARLY;
    end else if (w_e01) begin
      w_code = ERR_MISSING;
    end else if (w_e11) begin
      w_code = ERR_LONG;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rem    <= 2'd0;
      r_run    <= '0;
      r_err    <= 1'b0;
      r_code   <= ERR_NONE;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_rem    <= w_rem_nx;
      r_run    <= w_run_nx;
      r_err    <= (w_code != ERR_NONE);
      r_code   <= w_code;
      r_sticky <= r_sticky | (w_code != ERR_NONE);
    end
  end

  assign req_o        = reset ? w_req : 2'd0;
  assign run_o        = r_run;
  assign err_o        = r_err;
  assign err_code_o   = r_code;
  assign err_sticky_o = r_sticky;

`ifdef STALL_MON_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_hazard_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_hazard_start;

  assign w_hazard_start = (r_state == IDLE) && (w_state_nx == CHK);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_hazard_cnt <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (stall_i && !ext_stall_i && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_hazard_start && (r_hazard_cnt != '1)) begin
        r_hazard_cnt <= r_hazard_cnt + 1'b1;
      end
      if ((w_code != ERR_NONE) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign hazard_cnt_o = r_hazard_cnt;
  assign err_cnt_o    = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_monitor.sv
`default_nettype none
// Testbench for hazard_stall_monitor: directed scenarios plus randomized
// traffic checked against a cycle-level model of the stall rules.
module tb_hazard_stall_monitor;

  localparam int REG_W     = 5;
  localparam int MAX_STALL = 2;
  localparam int RUN_W     = 4;
  localparam int CNT_W     = 32;

  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_OPIMM  = 7'b0010011;
  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_AMO    = 7'b0101111;

  logic             clk;
  logic             reset;
  logic             id_valid_i;
  logic [6:0]       id_opcode_i;
  logic [REG_W-1:0] id_rs1_i;
  logic [REG_W-1:0] id_rs2_i;
  logic [1:0]       id_branch_i;
  logic [6:0]       ex_opcode_i;
  logic [REG_W-1:0] ex_rd_i;
  logic             ex_regwr_i;
  logic [6:0]       mem_opcode_i;
  logic [REG_W-1:0] mem_rd_i;
  logic             stall_i;
  logic             ext_stall_i;
  logic             flush_i;
  logic [1:0]       req_o;
  logic [RUN_W-1:0] run_o;
  logic             err_o;
  logic [1:0]       err_code_o;
  logic             err_sticky_o;
`ifdef STALL_MON_STATS_EN
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] hazard_cnt_o;
  logic [CNT_W-1:0] err_cnt_o;
`endif

  hazard_stall_monitor #(
    .REG_W(REG_W), .MAX_STALL(MAX_STALL), .RUN_W(RUN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_branch_i(id_branch_i),
    .ex_opcode_i(ex_opcode_i), .ex_rd_i(ex_rd_i), .ex_regwr_i(ex_regwr_i),
    .mem_opcode_i(mem_opcode_i), .mem_rd_i(mem_rd_i),
    .stall_i(stall_i), .ext_stall_i(ext_stall_i), .flush_i(flush_i),
    .req_o(req_o), .run_o(run_o), .err_o(err_o), .err_code_o(err_code_o),
    .err_sticky_o(err_sticky_o)
`ifdef STALL_MON_STATS_EN
    , .stall_cnt_o(stall_cnt_o), .hazard_cnt_o(hazard_cnt_o), .err_cnt_o(err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: m_owed < 0 means not tracking a hazard, otherwise stall
  // cycles still owed by the hazard unit.
  int m_owed = -1;
  int m_run  = 0;
  int m_code = 0;
  bit m_sticky = 1'b0;
  int m_hz = 0, m_stl = 0, m_errc = 0;
  int peak_run = 0;

  function automatic bit depends(input logic [REG_W-1:0] rd);
    bit s1, s2;
    s1 = !(id_opcode_i inside {O_LUI, O_AUIPC, O_JAL});
    s2 = id_opcode_i inside {O_BRANCH, O_STORE, O_OP, O_AMO};
    if (rd == 0) return 1'b0;
    return (s1 && id_rs1_i == rd) || (s2 && id_rs2_i == rd);
  endfunction

  function automatic int model_req();
    int r = 0;
    bit br;
    if (!reset || !id_valid_i) return 0;
    br = (id_branch_i == 2'b01);
    if (br && ex_opcode_i == O_LOAD && depends(ex_rd_i)) r = (r > 2) ? r : 2;
    if (br && ex_regwr_i && ex_opcode_i != O_LOAD && depends(ex_rd_i)) r = (r > 1) ? r : 1;
    if (br && mem_opcode_i == O_LOAD && depends(mem_rd_i)) r = (r > 1) ? r : 1;
    if (!br && ex_opcode_i == O_LOAD && depends(ex_rd_i)) r = (r > 1) ? r : 1;
    return r;
  endfunction

  task automatic model_step(input int req);
    bit missing = 0, early = 0, toolong = 0;
    int sat = (1 << RUN_W) - 1;
    if (!reset) begin
      m_owed = -1; m_run = 0; m_code = 0; m_sticky = 0;
      m_hz = 0; m_stl = 0; m_errc = 0;
      return;
    end
    if (stall_i && !ext_stall_i) m_stl++;
    if (flush_i) begin
      m_owed = -1;
      m_run  = 0;
    end else if (!ext_stall_i) begin
      if (m_owed < 0) begin
        if (req > 0 && !stall_i) missing = 1;
        if (req > 0 && stall_i) begin m_owed = req - 1; m_hz++; end
      end else if (m_owed == 0) begin
        m_owed = -1;
      end else if (stall_i) begin
        m_owed = m_owed - 1;
      end else begin
        early = 1;
        m_owed = -1;
      end
      if (stall_i) begin
        if (m_run + 1 == MAX_STALL + 1) toolong = 1;
        m_run = (m_run + 1 > sat) ? sat : m_run + 1;
      end else begin
        m_run = 0;
      end
    end
    m_code = early ? 2 : (missing ? 1 : (toolong ? 3 : 0));
    if (m_code != 0) begin m_sticky = 1; m_errc++; end
  endtask

  task automatic cycle();
    int req;
    #1;
    req = model_req();
    total++;
    if (req_o !== 2'(req)) begin
      bad++; $display("FAIL req_o: got %0d expected %0d at %0t", req_o, req, $time);
    end
    model_step(req);
    @(posedge clk); #1;
    total++;
    if (err_o !== (m_code != 0) || err_code_o !== 2'(m_code)) begin
      bad++; $display("FAIL err: got err=%0b code=%0d expected err=%0b code=%0d at %0t",
                      err_o, err_code_o, (m_code != 0), m_code, $time);
    end
    total++;
    if (run_o !== RUN_W'(m_run)) begin
      bad++; $display("FAIL run_o: got %0d expected %0d at %0t", run_o, m_run, $time);
    end
    total++;
    if (err_sticky_o !== m_sticky) begin
      bad++; $display("FAIL sticky: got %0b expected %0b at %0t", err_sticky_o, m_sticky, $time);
    end
`ifdef STALL_MON_STATS_EN
    total++;
    if (stall_cnt_o !== CNT_W'(m_stl) || hazard_cnt_o !== CNT_W'(m_hz) || err_cnt_o !== CNT_W'(m_errc)) begin
      bad++; $display("FAIL stats: got stall=%0d hz=%0d err=%0d expected %0d %0d %0d",
                      stall_cnt_o, hazard_cnt_o, err_cnt_o, m_stl, m_hz, m_errc);
    end
`endif
    if (int'(run_o) > peak_run) peak_run = int'(run_o);
  endtask

  task automatic set_idle();
    id_valid_i = 0; id_opcode_i = O_OPIMM; id_rs1_i = 0; id_rs2_i = 0; id_branch_i = 0;
    ex_opcode_i = O_OPIMM; ex_rd_i = 0; ex_regwr_i = 0;
    mem_opcode_i = O_OPIMM; mem_rd_i = 0;
    stall_i = 0; ext_stall_i = 0; flush_i = 0;
  endtask

  task automatic set_branch_load();
    id_valid_i = 1; id_opcode_i = O_BRANCH; id_rs1_i = 5; id_rs2_i = 5; id_branch_i = 2'b01;
    ex_opcode_i = O_LOAD; ex_rd_i = 5; ex_regwr_i = 1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 0;
    cycle(); cycle();
    reset = 1;
  endtask

  task automatic test_reset();
    set_branch_load();
    stall_i = 1;
    reset = 0;
    cycle(); cycle();
    total++;
    if (req_o !== 2'd0 || run_o !== '0 || err_o !== 1'b0 || err_code_o !== 2'b00 || err_sticky_o !== 1'b0) begin
      bad++; $display("FAIL reset_state: req=%0d run=%0d err=%0b code=%0d sticky=%0b expected all 0",
                      req_o, run_o, err_o, err_code_o, err_sticky_o);
    end
    reset = 1;
    set_idle();
  endtask

  task automatic test_branch_load();
    do_reset();
    set_branch_load();
    #1;
    total++;
    if (req_o !== 2'd2) begin bad++; $display("FAIL branch_req: got %0d expected 2", req_o); end
    peak_run = 0;
    stall_i = 1; cycle();
    stall_i = 1; cycle();
    stall_i = 0; cycle();
    total++;
    if (peak_run != 2 || err_o !== 1'b0 || err_sticky_o !== 1'b0) begin
      bad++; $display("FAIL branch_ok: peak=%0d err=%0b sticky=%0b expected 2 0 0", peak_run, err_o, err_sticky_o);
    end
    set_idle(); cycle();
  endtask

  task automatic test_early_release();
    do_reset();
    set_branch_load();
    stall_i = 1; cycle();
    stall_i = 0; cycle();
    total++;
    if (err_o !== 1'b1 || err_code_o !== 2'b10 || err_sticky_o !== 1'b1) begin
      bad++; $display("FAIL early: err=%0b code=%0d sticky=%0b expected 1 2 1", err_o, err_code_o, err_sticky_o);
    end
    set_idle(); cycle();
    total++;
    if (err_o !== 1'b0 || err_sticky_o !== 1'b1) begin
      bad++; $display("FAIL early_pulse: err=%0b sticky=%0b expected 0 1", err_o, err_sticky_o);
    end
  endtask

  task automatic test_missing();
    do_reset();
    id_valid_i = 1; id_opcode_i = O_OP; id_rs1_i = 7; id_rs2_i = 3; id_branch_i = 0;
    ex_opcode_i = O_LOAD; ex_rd_i = 7; ex_regwr_i = 1;
    stall_i = 0; cycle();
    total++;
    if (err_o !== 1'b1 || err_code_o !== 2'b01) begin
      bad++; $display("FAIL missing: err=%0b code=%0d expected 1 1", err_o, err_code_o);
    end
    id_rs1_i = 0; ex_rd_i = 0;
    cycle();
    total++;
    if (req_o !== 2'd0 || err_o !== 1'b0) begin
      bad++; $display("FAIL x0_dep: req=%0d err=%0b expected 0 0", req_o, err_o);
    end
    set_idle(); cycle();
  endtask

  task automatic test_run();
    do_reset();
    stall_i = 1; cycle(); cycle(); cycle();
    total++;
    if (err_o !== 1'b1 || err_code_o !== 2'b11 || run_o !== RUN_W'(3)) begin
      bad++; $display("FAIL too_long: err=%0b code=%0d run=%0d expected 1 3 3", err_o, err_code_o, run_o);
    end
    stall_i = 0; cycle();
    do_reset();
    stall_i = 1; cycle();
    ext_stall_i = 1; cycle();
    ext_stall_i = 0; cycle();
    total++;
    if (err_o !== 1'b0 || run_o !== RUN_W'(2) || err_sticky_o !== 1'b0) begin
      bad++; $display("FAIL ext_excused: err=%0b run=%0d sticky=%0b expected 0 2 0", err_o, run_o, err_sticky_o);
    end
    set_idle(); cycle();
  endtask

  task automatic test_flush();
    do_reset();
    set_branch_load();
    stall_i = 1; cycle();
    flush_i = 1; stall_i = 1; cycle();
    set_idle(); cycle();
    total++;
    if (err_o !== 1'b0 || err_sticky_o !== 1'b0 || run_o !== '0) begin
      bad++; $display("FAIL flush: err=%0b sticky=%0b run=%0d expected 0 0 0", err_o, err_sticky_o, run_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall_i = 1; cycle(); cycle();
    reset = 0; cycle();
    total++;
    if (run_o !== '0 || err_o !== 1'b0 || err_sticky_o !== 1'b0 || req_o !== 2'd0) begin
      bad++; $display("FAIL reset_mid: run=%0d err=%0b sticky=%0b req=%0d expected 0", run_o, err_o, err_sticky_o, req_o);
    end
    reset = 1;
    set_idle(); cycle();
  endtask

`ifdef STALL_MON_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_branch_load();
      stall_i = 1; cycle(); cycle();
      set_idle(); cycle();
    end
    total++;
    if (hazard_cnt_o !== CNT_W'(2) || stall_cnt_o !== CNT_W'(4) || err_cnt_o !== CNT_W'(0)) begin
      bad++; $display("FAIL stats_directed: hz=%0d stall=%0d err=%0d expected 2 4 0",
                      hazard_cnt_o, stall_cnt_o, err_cnt_o);
    end
  endtask
`endif

  task automatic test_random();
    logic [6:0] ops [10];
    ops = '{O_LOAD, O_STORE, O_BRANCH, O_OP, O_OPIMM, O_LUI, O_AUIPC, O_JAL, O_JALR, O_AMO};
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 99) != 0);
      id_valid_i   = ($urandom_range(0, 9) != 0);
      id_opcode_i  = ops[$urandom_range(0, 9)];
      id_rs1_i     = REG_W'($urandom_range(0, 3));
      id_rs2_i     = REG_W'($urandom_range(0, 3));
      id_branch_i  = 2'($urandom_range(0, 3));
      ex_opcode_i  = ($urandom_range(0, 1) != 0) ? O_LOAD : ops[$urandom_range(0, 9)];
      ex_rd_i      = REG_W'($urandom_range(0, 3));
      ex_regwr_i   = 1'($urandom_range(0, 1));
      mem_opcode_i = ($urandom_range(0, 1) != 0) ? O_LOAD : ops[$urandom_range(0, 9)];
      mem_rd_i     = REG_W'($urandom_range(0, 3));
      stall_i      = ($urandom_range(0, 99) < 55);
      ext_stall_i  = ($urandom_range(0, 99) < 10);
      flush_i      = ($urandom_range(0, 99) < 5);
      cycle();
    end
    reset = 1;
    set_idle(); cycle();
  endtask

  initial begin
    reset = 0;
    set_idle();
    @(posedge clk); #1;
    test_reset();
    test_branch_load();
    test_early_release();
    test_missing();
    test_run();
    test_flush();
    test_reset_mid();
`ifdef STALL_MON_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
